// File: rtl/binarize_thr_ctrl.sv
// rtl/binarize_thr_ctrl.sv - frame-atomic YCbCr threshold scheduler with optional auto Y window
// Host writes land in shadow registers; they are committed to the active outputs one cycle after vsync rises.
module binarize_thr_ctrl #(
    parameter int         IMG_HDISP  = 640,
    parameter int         ROI_UP     = 44,
    parameter int         ROI_DOWN   = 380,
    parameter int         ROI_LEFT   = 47,
    parameter int         ROI_RIGHT  = 567,
    parameter logic [7:0] Y_MAX_INIT = 8'd60,
    parameter logic [2:0] FLAG_INIT  = 3'b111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_clken,
    input  logic [7:0]  per_img_Y,
    input  logic        auto_en,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    output logic [7:0]  Y_max,
    output logic [7:0]  Y_min,
    output logic [7:0]  Cb_max,
    output logic [7:0]  Cb_min,
    output logic [7:0]  Cr_max,
    output logic [7:0]  Cr_min,
    output logic [2:0]  flag,
    output logic        auto_done,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_COMMIT} state_t;

    state_t      state_q, state_d;
    logic        vs_q;
    logic        vs_rise;
    logic        commit;
    logic        cfg_fire;

    logic [7:0]  sh_ymax_q, sh_ymin_q, sh_cbmax_q, sh_cbmin_q, sh_crmax_q, sh_crmin_q;
    logic [2:0]  sh_flag_q;

    logic [7:0]  ymax_q, ymin_q, cbmax_q, cbmin_q, crmax_q, crmin_q;
    logic [2:0]  flag_q;
    logic        auto_done_q;
    logic [15:0] frame_cnt_q;

    logic [9:0]  x_q, y_q;
    logic [7:0]  acc_min_q, acc_max_q;
    logic        roi_hit_q;
    logic        in_roi;
    logic        acc_en;
    logic [8:0]  acc_sum;

    assign vs_rise  = per_frame_vsync & ~vs_q;
    assign commit   = (state_q == S_COMMIT);
    assign cfg_ready = ~commit;
    assign cfg_fire = cfg_valid & cfg_ready;

    assign in_roi = (x_q >= 10'(ROI_LEFT)) && (x_q <= 10'(ROI_RIGHT)) &&
                    (y_q >= 10'(ROI_UP))   && (y_q <= 10'(ROI_DOWN));
    assign acc_en = (state_q == S_FRAME) & per_frame_clken & ~per_frame_vsync & in_roi;
    assign acc_sum = {1'b0, acc_min_q} + {1'b0, acc_max_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (vs_rise) state_d = S_COMMIT;
            S_FRAME:  if (vs_rise) state_d = S_COMMIT;
            S_COMMIT: state_d = S_FRAME;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= per_frame_vsync;
        end
    end

    // Shadows are never written during S_COMMIT, so the commit always sees a stable set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_ymax_q  <= Y_MAX_INIT;
            sh_ymin_q  <= 8'd0;
            sh_cbmax_q <= 8'd255;
            sh_cbmin_q <= 8'd0;
            sh_crmax_q <= 8'd255;
            sh_crmin_q <= 8'd0;
            sh_flag_q  <= FLAG_INIT;
        end else if (cfg_fire) begin
            case (cfg_addr)
                3'd0:    sh_ymax_q  <= cfg_data;
                3'd1:    sh_ymin_q  <= cfg_data;
                3'd2:    sh_cbmax_q <= cfg_data;
                3'd3:    sh_cbmin_q <= cfg_data;
                3'd4:    sh_crmax_q <= cfg_data;
                3'd5:    sh_crmin_q <= cfg_data;
                3'd6:    sh_flag_q  <= cfg_data[2:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ymax_q      <= Y_MAX_INIT;
            ymin_q      <= 8'd0;
            cbmax_q     <= 8'd255;
            cbmin_q     <= 8'd0;
            crmax_q     <= 8'd255;
            crmin_q     <= 8'd0;
            flag_q      <= FLAG_INIT;
            auto_done_q <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            auto_done_q <= 1'b0;
            if (commit) begin
                cbmax_q     <= sh_cbmax_q;
                cbmin_q     <= sh_cbmin_q;
                crmax_q     <= sh_crmax_q;
                crmin_q     <= sh_crmin_q;
                flag_q      <= sh_flag_q;
                frame_cnt_q <= frame_cnt_q + 16'd1;
                if (auto_en && roi_hit_q) begin
                    ymax_q      <= acc_sum[8:1];
                    ymin_q      <= 8'd0;
                    auto_done_q <= 1'b1;
                end else begin
                    ymax_q <= sh_ymax_q;
                    ymin_q <= sh_ymin_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= 10'd0;
            y_q <= 10'd0;
        end else if (per_frame_vsync) begin
            x_q <= 10'd0;
            y_q <= 10'd0;
        end else if (per_frame_clken) begin
            if (x_q == 10'(IMG_HDISP - 1)) begin
                x_q <= 10'd0;
                y_q <= y_q + 10'd1;
            end else begin
                x_q <= x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_min_q <= 8'd255;
            acc_max_q <= 8'd0;
            roi_hit_q <= 1'b0;
        end else if (commit) begin
            acc_min_q <= 8'd255;
            acc_max_q <= 8'd0;
            roi_hit_q <= 1'b0;
        end else if (acc_en) begin
            if (per_img_Y < acc_min_q) acc_min_q <= per_img_Y;
            if (per_img_Y > acc_max_q) acc_max_q <= per_img_Y;
            roi_hit_q <= 1'b1;
        end
    end

    assign Y_max     = ymax_q;
    assign Y_min     = ymin_q;
    assign Cb_max    = cbmax_q;
    assign Cb_min    = cbmin_q;
    assign Cr_max    = crmax_q;
    assign Cr_min    = crmin_q;
    assign flag      = flag_q;
    assign auto_done = auto_done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_binarize_thr_ctrl.sv
// tb/tb_binarize_thr_ctrl.sv - directed self-checking bench for binarize_thr_ctrl
module tb_binarize_thr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        per_frame_vsync;
    logic        per_frame_clken;
    logic [7:0]  per_img_Y;
    logic        auto_en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic [7:0]  Y_max, Y_min, Cb_max, Cb_min, Cr_max, Cr_min;
    logic [2:0]  flag;
    logic        auto_done;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    binarize_thr_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_clken (per_frame_clken),
        .per_img_Y       (per_img_Y),
        .auto_en         (auto_en),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .Y_max           (Y_max),
        .Y_min           (Y_min),
        .Cb_max          (Cb_max),
        .Cb_min          (Cb_min),
        .Cr_max          (Cr_max),
        .Cr_min          (Cr_min),
        .flag            (flag),
        .auto_done       (auto_done),
        .frame_cnt       (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        cyc();
        cfg_valid = 1'b0;
    endtask

    function automatic logic [7:0] pixval(input int ln, input int px);
        if (ln < 44)  return 8'd0;
        if (px < 47)  return (px == 10) ? 8'd5 : 8'd0;
        if (px > 567) return (px == 568) ? 8'd255 : 8'd0;
        if (px == 47) return 8'd30;
        if (px == 48) return 8'd200;
        return 8'd100;
    endfunction

    initial begin
        int low_cnt;
        logic accepted;

        rst_n = 1'b0; per_frame_vsync = 1'b0; per_frame_clken = 1'b0; per_img_Y = 8'd0;
        auto_en = 1'b0; cfg_valid = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0;
        repeat (3) cyc();

        // Reset values
        chk("rst_ymax", 16'(Y_max), 16'd60);
        chk("rst_ymin", 16'(Y_min), 16'd0);
        chk("rst_cbmax", 16'(Cb_max), 16'd255);
        chk("rst_cbmin", 16'(Cb_min), 16'd0);
        chk("rst_crmax", 16'(Cr_max), 16'd255);
        chk("rst_crmin", 16'(Cr_min), 16'd0);
        chk("rst_flag", 16'(flag), 16'd7);
        chk("rst_fcnt", frame_cnt, 16'd0);
        chk("rst_autodone", 16'(auto_done), 16'd0);
        rst_n = 1'b1;
        cyc();
        chk("idle_ready", 16'(cfg_ready), 16'd1);

        // Shadow writes, then a long vsync produces one commit two cycles after the rise
        wr(3'd0, 8'd100); wr(3'd3, 8'd20); wr(3'd6, 8'hFA); wr(3'd7, 8'h55);
        cyc();
        chk("t2_ymax_hold", 16'(Y_max), 16'd60);
        chk("t2_cbmin_hold", 16'(Cb_min), 16'd0);
        chk("t2_flag_hold", 16'(flag), 16'd7);
        per_frame_vsync = 1'b1;
        cyc();
        chk("t2_ymax_c1", 16'(Y_max), 16'd60);
        chk("t2_ready_commit", 16'(cfg_ready), 16'd0);
        cyc();
        chk("t2_ymax", 16'(Y_max), 16'd100);
        chk("t2_cbmin", 16'(Cb_min), 16'd20);
        chk("t2_flag", 16'(flag), 16'd2);
        chk("t2_ymin_a7", 16'(Y_min), 16'd0);
        chk("t2_fcnt", frame_cnt, 16'd1);
        chk("t2_ready_after", 16'(cfg_ready), 16'd1);
        repeat (3) cyc();
        chk("t2_long_vs", frame_cnt, 16'd1);

        // Auto mode: ROI min 30, max 200 -> midpoint 115; out-of-ROI 5/255/0 ignored
        auto_en = 1'b1;
        wr(3'd1, 8'd7); wr(3'd4, 8'd200);
        per_frame_vsync = 1'b0;
        cyc();
        for (int ln = 0; ln < 45; ln++) begin
            for (int px = 0; px < 640; px++) begin
                per_frame_clken = 1'b1;
                per_img_Y = pixval(ln, px);
                cyc();
            end
        end
        per_frame_clken = 1'b0;
        cyc();
        per_frame_vsync = 1'b1;
        cyc(); cyc();
        chk("t3_ymax", 16'(Y_max), 16'd115);
        chk("t3_ymin", 16'(Y_min), 16'd0);
        chk("t3_autodone", 16'(auto_done), 16'd1);
        chk("t3_cbmin", 16'(Cb_min), 16'd20);
        chk("t3_crmax", 16'(Cr_max), 16'd200);
        chk("t3_fcnt", frame_cnt, 16'd2);
        cyc();
        chk("t3_autodone_pulse", 16'(auto_done), 16'd0);

        // Auto mode with no ROI pixels falls back to shadow Y values
        per_frame_vsync = 1'b0;
        repeat (20) cyc();
        per_frame_vsync = 1'b1;
        cyc(); cyc();
        chk("t4_ymax", 16'(Y_max), 16'd100);
        chk("t4_ymin", 16'(Y_min), 16'd7);
        chk("t4_autodone", 16'(auto_done), 16'd0);
        chk("t4_fcnt", frame_cnt, 16'd3);

        // Write pending across the commit cycle is stalled one cycle, then lands in the shadow
        per_frame_vsync = 1'b0;
        repeat (5) cyc();
        per_frame_vsync = 1'b1;
        cyc();
        cfg_valid = 1'b1; cfg_addr = 3'd1; cfg_data = 8'd9;
        low_cnt = 0;
        accepted = 1'b0;
        for (int k = 0; k < 10; k++) begin
            accepted = cfg_ready;
            if (!accepted) low_cnt++;
            cyc();
            if (accepted) break;
        end
        cfg_valid = 1'b0;
        chk("t5_ready_low", 16'(low_cnt), 16'd1);
        chk("t5_accepted", 16'(accepted), 16'd1);
        chk("t5_ymin_old", 16'(Y_min), 16'd7);
        chk("t5_fcnt", frame_cnt, 16'd4);
        per_frame_vsync = 1'b0;
        repeat (5) cyc();
        per_frame_vsync = 1'b1;
        cyc(); cyc();
        chk("t5_ymin_new", 16'(Y_min), 16'd9);
        chk("t5_fcnt2", frame_cnt, 16'd5);

        // Async reset mid-frame discards the pending shadow write
        per_frame_vsync = 1'b0;
        repeat (5) cyc();
        wr(3'd0, 8'd77);
        rst_n = 1'b0;
        #1;
        chk("t6_ymax_rst", 16'(Y_max), 16'd60);
        chk("t6_ymin_rst", 16'(Y_min), 16'd0);
        chk("t6_cbmin_rst", 16'(Cb_min), 16'd0);
        chk("t6_flag_rst", 16'(flag), 16'd7);
        chk("t6_fcnt_rst", frame_cnt, 16'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        per_frame_vsync = 1'b1;
        cyc(); cyc();
        chk("t6_ymax_lost", 16'(Y_max), 16'd60);
        chk("t6_cbmin_lost", 16'(Cb_min), 16'd0);
        chk("t6_fcnt", frame_cnt, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/binarize_thr_ctrl.md
Name: binarize_thr_ctrl

Overview:
Threshold scheduler/configurator for the YCbCr binarization stage. A host (key/UART decoder) writes Y/Cb/Cr min/max thresholds and a 3-bit mode flag into shadow registers. The block commits them atomically at frame boundaries (vsync rising edge), so the binarizer never sees a threshold change mid-frame. An optional auto mode measures Y min/max inside an ROI each frame and sets the Y window to the midpoint for the next frame.

Parameters:
IMG_HDISP, 640, active pixels per line (x counter wrap)
ROI_UP, 44, first ROI line (inclusive)
ROI_DOWN, 380, last ROI line (inclusive)
ROI_LEFT, 47, first ROI column (inclusive)
ROI_RIGHT, 567, last ROI column (inclusive)
Y_MAX_INIT, 60, reset value of Y_max
FLAG_INIT, 3'b111, reset value of flag

Ports:
clk  in  1  system clock (single clock domain)
rst_n  in  1  asynchronous, active-low reset
per_frame_vsync  in  1  frame sync, high during vertical blanking
per_frame_clken  in  1  pixel-valid strobe
per_img_Y  in  8  luma of current pixel
auto_en  in  1  1 = auto Y threshold mode
cfg_valid  in  1  host write request
cfg_ready  out  1  block accepts write this cycle
cfg_addr  in  3  0 Y_max, 1 Y_min, 2 Cb_max, 3 Cb_min, 4 Cr_max, 5 Cr_min, 6 flag, 7 reserved
cfg_data  in  8  write data (flag uses [2:0])
Y_max, Y_min, Cb_max, Cb_min, Cr_max, Cr_min  out  8 each  active thresholds to binarizer
flag  out  3  active mode flag
auto_done  out  1  1-cycle pulse when an auto threshold was applied
frame_cnt  out  16  committed-frame counter

Behaviour:
- Reset (async, rst_n=0): Y_max=Y_MAX_INIT, Y_min=0, Cb_max=Cr_max=255, Cb_min=Cr_min=0, flag=FLAG_INIT. Shadows take the same values. auto_done=0, frame_cnt=0, state=S_IDLE, x/y counters=0, acc_min=255, acc_max=0, roi_hit=0. A reset mid-frame discards pending shadow writes.
- vs_d registers per_frame_vsync; vs_rise = per_frame_vsync & ~vs_d.
- FSM:
  - S_IDLE: waits for the first vs_rise, then -> S_COMMIT.
  - S_FRAME: accumulates; on vs_rise -> S_COMMIT.
  - S_COMMIT: lasts 1 cycle, always -> S_FRAME.
- Commit happens on the clock edge leaving S_COMMIT. New thresholds are visible 2 cycles after the cycle in which vs_rise is sampled.
- Host handshake: cfg_ready=1 in S_IDLE and S_FRAME, and 0 in S_COMMIT. A write occurs when cfg_valid & cfg_ready; it updates the shadow for addr 0–6 only. Addr 7 is accepted and ignored. Back-to-back writes are allowed one per cycle; the last write to an address wins. Writes never touch active outputs directly.
- Commit:
  - All active regs <= shadows. frame_cnt += 1, wrapping 65535 -> 0.
  - If auto_en=1 and roi_hit=1: Y_max <= (acc_min + acc_max) >> 1, computed with a 9-bit sum and truncated; Y_min <= 0; auto_done=1 for that cycle. These override the Y shadows; Cb/Cr/flag still come from shadows.
  - If auto_en=1 and roi_hit=0: use shadow Y values; auto_done stays 0.
  - In every case, acc_min<=255, acc_max<=0, roi_hit<=0.
- Pixel counters:
  - per_frame_vsync=1 forces x=y=0.
  - Otherwise, on clken, x increments; at x=IMG_HDISP-1, x<=0 and y+=1. Both counters are 10-bit; y wraps naturally.
- Accumulation (S_FRAME, clken=1, vsync=0, ROI_LEFT<=x<=ROI_RIGHT, ROI_UP<=y<=ROI_DOWN): acc_min<=min(acc_min,Y), acc_max<=max(acc_max,Y), roi_hit<=1. Nothing is accumulated in S_IDLE or S_COMMIT.
- auto_en is sampled only at commit; toggling it mid-frame has no other effect.
- A vsync pulse longer than one cycle produces exactly one commit (edge-detected).

Test Plan:
1. Reset, no vsync -> outputs 60/0/255/0/255/0, flag=7, cfg_ready=1, frame_cnt=0.
2. Write addr0=100, addr3=20 mid-frame -> outputs unchanged. vsync rise -> Y_max=100, Cb_min=20 exactly 2 cycles later; frame_cnt=1.
3. auto_en=1; frame with ROI pixels Y=30..200, plus a Y=5 pixel outside the ROI (x=10) -> at commit Y_max=115, Y_min=0, auto_done pulses once; Cb/Cr from shadows.
4. auto_en=1; frame with no clken inside the ROI -> Y_max/Y_min = shadow values, auto_done=0.
5. cfg_valid held high across a vsync rise with addr1 data 9 -> cfg_ready=0 for exactly the S_COMMIT cycle, the write completes the next cycle, and Y_min=9 appears only after the following commit.
6. Assert rst_n=0 mid-frame after pending writes -> all outputs return to reset values immediately; the pending shadow write is lost at the next commit.
